// File: rtl/ram_fifo_pkg.sv
// Shared sizing constants and types for the RAM-backed FIFO controller.
// Sized for the 64x8 single-port RAM (ram_8bit) that sits next to the controller.
package ram_fifo_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   cnt_t;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Enable-gated wrapping pointer with synchronous active-high reset.
// It is used twice in the controller: once as the write pointer and once as the read pointer.
module ram_fifo_ptr
    import ram_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_en,
    output addr_t o_ptr
);

    addr_t r_ptr;

    // NOTE: sequential state uses non-blocking assignments, and reset is tested inside the clocked block (synchronous).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + addr_t'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external 64x8 single-port RAM. A pop takes priority over a push.
// Optional sticky overflow/underflow flags are enabled with the RAM_FIFO_STATS_EN macro.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  push_valid,
    input  word_t push_data,
    output logic  push_ready,
    input  logic  pop_req,
    output logic  pop_ack,
    output logic  pop_valid,
    output word_t pop_data,
    output cnt_t  count,
    output logic  full,
    output logic  empty,
    output word_t ram_data,
    output addr_t ram_addr,
    output logic  ram_we,
    input  word_t ram_q,
    output logic  push_err,
    output logic  pop_err
);

    cnt_t  r_count;
    logic  r_pop_valid;
    addr_t w_wr_ptr;
    addr_t w_rd_ptr;
    logic  w_empty;
    logic  w_full;
    logic  w_pop_ack;
    logic  w_push_ready;
    logic  w_push_fire;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == cnt_t'(DEPTH));
    assign w_pop_ack    = pop_req && !w_empty;
    // The RAM has one port, so a cycle spent reading cannot also write.
    assign w_push_ready = !w_full && !w_pop_ack;
    assign w_push_fire  = push_valid && w_push_ready;

    ram_fifo_ptr u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_push_fire),
        .o_ptr (w_wr_ptr)
    );

    ram_fifo_ptr u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_pop_ack),
        .o_ptr (w_rd_ptr)
    );

    // A pop and a push never both fire, so the count moves by at most one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_pop_ack;
            if (w_pop_ack) begin
                r_count <= r_count - cnt_t'(1);
            end else if (w_push_fire) begin
                r_count <= r_count + cnt_t'(1);
            end
        end
    end

    assign ram_we     = w_push_fire;
    assign ram_addr   = w_push_fire ? w_wr_ptr : w_rd_ptr;
    assign ram_data   = push_data;

    assign push_ready = w_push_ready;
    assign pop_ack    = w_pop_ack;
    assign pop_valid  = r_pop_valid;
    assign pop_data   = ram_q;
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;

`ifdef RAM_FIFO_STATS_EN
    logic r_push_err;
    logic r_pop_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_push_err <= 1'b0;
            r_pop_err  <= 1'b0;
        end else begin
            if (push_valid && w_full) r_push_err <= 1'b1;
            if (pop_req && w_empty)   r_pop_err  <= 1'b1;
        end
    end

    assign push_err = r_push_err;
    assign pop_err  = r_pop_err;
`else
    assign push_err = 1'b0;
    assign pop_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl. It uses a queue-based FIFO reference model and a behavioural 64x8 RAM.
// A monitor process checks pop_valid/pop_data against the expected words the driver pushes.
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  push_valid = 1'b0;
    word_t push_data = '0;
    logic  push_ready;
    logic  pop_req = 1'b0;
    logic  pop_ack;
    logic  pop_valid;
    word_t pop_data;
    cnt_t  count;
    logic  full;
    logic  empty;
    word_t ram_data;
    addr_t ram_addr;
    logic  ram_we;
    word_t ram_q;
    logic  push_err;
    logic  pop_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_req    (pop_req),
        .pop_ack    (pop_ack),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ram_data   (ram_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_q      (ram_q),
        .push_err   (push_err),
        .pop_err    (pop_err)
    );

    // Behavioural single-port RAM: write on the edge, with a read latency of one cycle.
    word_t mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    // Reference model state
    word_t model_q[$];
    word_t exp_q[$];
    int    wr_idx = 0;
    int    rd_idx = 0;
    bit    m_push_err = 1'b0;
    bit    m_pop_err  = 1'b0;
    bit    mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs against the model, then advance the model.
    task automatic step(input logic pv, input word_t pd, input logic pr, input logic r);
        int  sz;
        bit  e_ack, e_rdy, fire;
        sz    = model_q.size();
        e_ack = pr && (sz != 0);
        e_rdy = (sz != DEPTH) && !e_ack;
        fire  = pv && e_rdy;
        @(negedge clk);
        push_valid = pv;
        push_data  = pd;
        pop_req    = pr;
        rst        = r;
        #1;
        check("count",      32'(count), 32'(sz));
        check("empty",      32'(empty), 32'(sz == 0));
        check("full",       32'(full), 32'(sz == DEPTH));
        check("pop_ack",    32'(pop_ack), 32'(e_ack));
        check("push_ready", 32'(push_ready), 32'(e_rdy));
        check("ram_we",     32'(ram_we), 32'(fire));
        check("ram_addr",   32'(ram_addr), fire ? wr_idx : rd_idx);
        if (fire) check("ram_data", 32'(ram_data), 32'(pd));
        check("push_err",   32'(push_err), 32'(m_push_err));
        check("pop_err",    32'(pop_err), 32'(m_pop_err));
        if (r) begin
            model_q.delete();
            wr_idx = 0;
            rd_idx = 0;
            m_push_err = 1'b0;
            m_pop_err  = 1'b0;
        end else begin
`ifdef RAM_FIFO_STATS_EN
            if (pv && sz == DEPTH) m_push_err = 1'b1;
            if (pr && sz == 0)     m_pop_err  = 1'b1;
`endif
            if (e_ack) begin
                exp_q.push_back(model_q.pop_front());
                rd_idx = (rd_idx + 1) % DEPTH;
            end
            if (fire) begin
                model_q.push_back(pd);
                wr_idx = (wr_idx + 1) % DEPTH;
            end
        end
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) step(1'b1, word_t'(base + i), 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Monitor: every cycle, pop_valid must match whether the scoreboard holds a word.
    initial begin
        word_t e;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pop_valid", 32'(pop_valid), 32'd1);
                check("pop_data",  32'(pop_data), 32'(e));
            end else begin
                check("pop_valid_idle", 32'(pop_valid), 32'd0);
            end
        end
    end

    initial begin
        word_t pend;
        bit    has_pend;
        int    push_pct;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);

        // Reset state, then four pushes and four pops.
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h06, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h04, 1'b0, 1'b0);
        pop_n(4);
        step(1'b0, '0, 1'b1, 1'b0);   // pop on an empty FIFO
        step(1'b0, '0, 1'b0, 1'b0);

        // Fill to full, attempt a rejected 65th push, then drain.
        step(1'b0, '0, 1'b0, 1'b1);
        push_n(DEPTH, 0);
        step(1'b1, 8'h09, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        pop_n(DEPTH);
        step(1'b0, '0, 1'b0, 1'b0);

        // Wrap-around across address 63 -> 0.
        step(1'b0, '0, 1'b0, 1'b1);
        push_n(60, 8'h40);
        pop_n(60);
        push_n(8, 8'hA0);
        pop_n(8);
        step(1'b0, '0, 1'b0, 1'b0);

        // Contention with count=2: pops win, then the held push lands once empty.
        push_n(2, 8'h30);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h5A, 1'b1, 1'b0);
        pop_n(2);
        step(1'b0, '0, 1'b0, 1'b0);

        // Reset with a pop in flight at count=5.
        step(1'b0, '0, 1'b0, 1'b1);
        push_n(6, 8'h70);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Randomised traffic with changing push/pop bias so both full and empty are reached.
        has_pend = 1'b0;
        pend = '0;
        push_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            bit pv, pr;
            if (c % 250 == 0) push_pct = (c / 250) % 2 ? 20 : 85;
            pv = ($urandom_range(99) < push_pct);
            pr = ($urandom_range(99) >= push_pct);
            if (pv && !has_pend) begin
                pend = word_t'($urandom);
                has_pend = 1'b1;
            end
            if (pv && model_q.size() != DEPTH && !(pr && model_q.size() != 0)) begin
                step(1'b1, pend, pr, 1'b0);
                has_pend = 1'b0;
            end else begin
                step(pv, pend, pr, 1'b0);
            end
        end

        pop_n(DEPTH);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
FIFO controller placed directly upstream of the 64x8 single-port RAM (ram_8bit). It turns a push/pop stream interface into the RAM's data/addr/we drive and returns the RAM's q as pop data. It owns the write/read pointers, the occupancy count and single-port arbitration. The RAM itself stays outside this block.

Parameters:
DATA_W, 8, word width; matches the RAM data and q width.
ADDR_W, 6, RAM address width.
DEPTH, 2**ADDR_W (64), FIFO capacity in words.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
push_valid  in  1  producer offers push_data this cycle.
push_data  in  DATA_W  word to enqueue.
push_ready  out  1  push accepted this cycle when push_valid && push_ready.
pop_req  in  1  consumer requests one word.
pop_ack  out  1  pop_req accepted this cycle (a RAM read is issued).
pop_valid  out  1  pop_data valid; asserts exactly 1 cycle after pop_ack.
pop_data  out  DATA_W  dequeued word, driven directly from ram_q.
count  out  ADDR_W+1  current occupancy, 0..DEPTH.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
ram_data  out  DATA_W  to RAM data.
ram_addr  out  ADDR_W  to RAM addr.
ram_we  out  1  to RAM we.
ram_q  in  DATA_W  from RAM q.
push_err  out  1  sticky overflow flag (optional feature).
pop_err  out  1  sticky underflow flag (optional feature).

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high.
- RAM contract: write on the rising edge when ram_we=1. ram_q presents the word at the address sampled on the previous edge, so read latency is 1 cycle.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, push_err=0, pop_err=0. As a consequence empty=1, full=0.
- One RAM operation per cycle, with pop priority:
  - pop_ack = pop_req && !empty.
  - push_ready = !full && !pop_ack. This is combinational from pop_req and count.
- Read cycle (pop_ack=1): ram_addr=rd_ptr, ram_we=0. On the edge, rd_ptr+1 and count-1. Next cycle: pop_valid=1 and pop_data=ram_q.
- Write cycle (push_valid && push_ready): ram_addr=wr_ptr, ram_data=push_data, ram_we=1. On the edge, wr_ptr+1 and count+1.
- Idle cycle: ram_we=0, ram_addr=rd_ptr, ram_data=push_data.
- Pointers: ADDR_W bits; they wrap 63 -> 0 naturally with no special case.
- count: ADDR_W+1 bits; never exceeds DEPTH and never goes below 0.
- Simultaneous push_valid and pop_req on a non-empty FIFO: the pop is served and the push stalls (push_ready=0). The producer holds push_data until accepted.
- Simultaneous push_valid and pop_req on an empty FIFO: pop_ack=0, so the push is accepted. A new word is not poppable until the cycle after its write.
- Full: push_ready=0 and a pop is still allowed. Empty: pop_ack=0 and a push is still allowed.
- pop_valid is a registered copy of pop_ack. It asserts back-to-back under continuous pops.
- Reset mid-operation: all pointers and the count clear on that edge. A pop issued in the reset cycle does not raise pop_valid. RAM contents are not cleared but become unreachable.

Optional Feature:
RAM_FIFO_STATS_EN
- Defined:
  - push_err sets on any cycle with push_valid && full.
  - pop_err sets on any cycle with pop_req && empty.
  - Both flags stay set until rst.
- Undefined: push_err and pop_err are tied 0 and no flag registers are generated. The ports remain present.

Decomposition:
- Package ram_fifo_pkg: DATA_W, ADDR_W, DEPTH constants; typedefs addr_t (ADDR_W bits), cnt_t (ADDR_W+1 bits), word_t (DATA_W bits).
- Sub-module ram_fifo_ptr: enable-gated ADDR_W-bit wrapping pointer with synchronous reset. It is instantiated twice, for write and read.

Test Plan:
- Reset, then push 8'h01, 8'h06, 8'h02, 8'h04 -> RAM writes at addresses 0..3, count=4, empty=0.
- From that state, pop_req for 4 cycles -> pop_valid on cycles 2..5 with pop_data 8'h01, 8'h06, 8'h02, 8'h04; then empty=1.
- Push 64 words 8'h00..8'h3F -> full=1, count=64, push_ready=0. A 65th push (8'h09) is rejected and sets push_err with the macro defined. Popping all 64 returns 8'h00..8'h3F in order.
- Wrap-around: pre-fill 60 words and pop 60, then push 8 words 8'hA0..8'hA7 -> writes at addresses 60..63 then 0..3. Pops return 8'hA0..8'hA7.
- Hold push_valid and pop_req together with count=2 -> pop_ack=1, push_ready=0 for 2 cycles. Then the push is accepted once empty.
- Assert rst at count=5 with a pop in flight -> next cycle count=0, empty=1, pop_valid=0, flags=0.
